// File: rtl/nh_lcd_data_reader.sv
// Read-back engine for the 8080-style LCD bus: issues the memory-read command, a dummy read,
// then reads pixels byte by byte (MSB first) and hands them out over a valid/ready port.
module nh_lcd_data_reader #(
  parameter int unsigned DATAS_WIDTH   = 24,
  parameter logic [7:0]  READ_CMD      = 8'h2E,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_enable,
  input  logic                   i_start_stb,
  input  logic [31:0]            i_num_pixels,
  output logic                   o_busy,
  output logic                   o_done_stb,
  output logic [DATAS_WIDTH-1:0] o_pixel_data,
  output logic                   o_pixel_stb,
  input  logic                   i_pixel_rdy,
  output logic                   o_cmd_mode,
  output logic                   o_write,
  output logic                   o_read,
  output logic [7:0]             o_data_out,
  output logic                   o_data_out_en,
  input  logic [7:0]             i_data_in
);

  localparam int unsigned NumBytes   = DATAS_WIDTH / 8;
  localparam logic [15:0] StrobeLast = 16'(STROBE_CYCLES - 1);
  localparam logic [15:0] HoldLast   = 16'(HOLD_CYCLES - 1);
  localparam logic [1:0]  ByteLast   = 2'(NumBytes - 1);

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StCmdWr   = 4'd1;
  localparam logic [3:0] StCmdHold = 4'd2;
  localparam logic [3:0] StTurn    = 4'd3;
  localparam logic [3:0] StDmyRd   = 4'd4;
  localparam logic [3:0] StDmyHold = 4'd5;
  localparam logic [3:0] StRd      = 4'd6;
  localparam logic [3:0] StRdHold  = 4'd7;
  localparam logic [3:0] StPush    = 4'd8;
  localparam logic [3:0] StDone    = 4'd9;

  logic [3:0]             r_state;
  logic [15:0]            r_cyc;
  logic [1:0]             r_byte_idx;
  logic [31:0]            r_num;
  logic [31:0]            r_pix_cnt;
  logic [DATAS_WIDTH-1:0] r_pixel;
  logic                   r_pix_stb;

  logic [3:0]  w_state_nxt;
  logic        w_xfer;
  logic        w_strobe_end;
  logic        w_hold_end;
  logic        w_last_byte;
  logic [31:0] w_cnt_inc;
  logic        w_all_done;
  logic        w_cmd_phase;

  always_comb begin
    w_xfer       = r_pix_stb & i_pixel_rdy;
    w_strobe_end = (r_cyc == StrobeLast);
    w_hold_end   = (r_cyc == HoldLast);
    w_last_byte  = (r_byte_idx == ByteLast);
    // Count including a transfer happening this very cycle.
    w_cnt_inc    = r_pix_cnt + 32'(w_xfer);
    w_all_done   = (w_cnt_inc == r_num);
    w_state_nxt  = r_state;
    case (r_state)
      StIdle:    if (i_start_stb) w_state_nxt = (i_num_pixels == 32'd0) ? StDone : StCmdWr;
      StCmdWr:   if (w_strobe_end) w_state_nxt = StCmdHold;
      StCmdHold: if (w_hold_end) w_state_nxt = StTurn;
      StTurn:    w_state_nxt = StDmyRd;
      StDmyRd:   if (w_strobe_end) w_state_nxt = StDmyHold;
      StDmyHold: if (w_hold_end) w_state_nxt = StRd;
      StRd:      if (w_strobe_end) w_state_nxt = StRdHold;
      StRdHold: begin
        if (w_hold_end) begin
          if (!w_last_byte)                   w_state_nxt = StRd;
          else if (r_pix_stb && !i_pixel_rdy) w_state_nxt = StPush;
          else if (w_all_done)                w_state_nxt = StDone;
          else                                w_state_nxt = StRd;
        end
      end
      StPush:    if (w_xfer) w_state_nxt = w_all_done ? StDone : StRd;
      StDone:    w_state_nxt = StIdle;
      default:   w_state_nxt = StIdle;
    endcase
    if (!i_enable) w_state_nxt = StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cyc      <= '0;
      r_byte_idx <= '0;
      r_num      <= '0;
      r_pix_cnt  <= '0;
      r_pixel    <= '0;
      r_pix_stb  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= (w_state_nxt != r_state || r_state == StIdle) ? '0 : r_cyc + 16'd1;
      if (r_state == StIdle && i_start_stb) begin
        r_num      <= i_num_pixels;
        r_pix_cnt  <= '0;
        r_byte_idx <= '0;
      end
      if (r_state == StRd && w_strobe_end) begin
        r_pixel <= (r_pixel << 8) | DATAS_WIDTH'(i_data_in);
        if (w_last_byte) r_pix_stb <= 1'b1;
      end
      if (r_state == StRdHold && w_hold_end) begin
        r_byte_idx <= w_last_byte ? 2'd0 : r_byte_idx + 2'd1;
      end
      if (w_xfer) begin
        r_pix_stb <= 1'b0;
        r_pix_cnt <= r_pix_cnt + 32'd1;
      end
      if (!i_enable) r_pix_stb <= 1'b0;
    end
  end

  assign w_cmd_phase   = (r_state == StCmdWr) || (r_state == StCmdHold);
  assign o_busy        = (r_state != StIdle) && (r_state != StDone);
  assign o_done_stb    = (r_state == StDone);
  assign o_pixel_data  = r_pixel;
  assign o_pixel_stb   = r_pix_stb;
  assign o_cmd_mode    = !w_cmd_phase;
  assign o_write       = (r_state == StCmdWr);
  assign o_read        = (r_state == StDmyRd) || (r_state == StRd);
  assign o_data_out    = w_cmd_phase ? READ_CMD : 8'h00;
  assign o_data_out_en = w_cmd_phase;

endmodule

// File: tb/tb_nh_lcd_data_reader.sv
// Bench for nh_lcd_data_reader: per-cycle output traces checked against hand-derived masks,
// pixels checked by a scoreboard monitor against an LCD byte-stream model.
module tb_nh_lcd_data_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_enable = 1'b1;
  logic        i_start_stb = 1'b0;
  logic [31:0] i_num_pixels = '0;
  logic        o_busy, o_done_stb, o_pixel_stb, o_cmd_mode, o_write, o_read, o_data_out_en;
  logic [23:0] o_pixel_data;
  logic        i_pixel_rdy = 1'b1;
  logic [7:0]  o_data_out;
  logic [7:0]  i_data_in;

  nh_lcd_data_reader dut (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (i_enable),
    .i_start_stb  (i_start_stb),
    .i_num_pixels (i_num_pixels),
    .o_busy       (o_busy),
    .o_done_stb   (o_done_stb),
    .o_pixel_data (o_pixel_data),
    .o_pixel_stb  (o_pixel_stb),
    .i_pixel_rdy  (i_pixel_rdy),
    .o_cmd_mode   (o_cmd_mode),
    .o_write      (o_write),
    .o_read       (o_read),
    .o_data_out   (o_data_out),
    .o_data_out_en(o_data_out_en),
    .i_data_in    (i_data_in)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [23:0] exp_q[$];
  logic [7:0]  bus_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // LCD model: byte stream restarts on each command write, advances when RD strobe drops.
  int   bus_idx = 0;
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;
  always @(negedge clk) begin
    if (o_write && !prev_wr) bus_idx = 0;
    else if (prev_rd && !o_read) bus_idx++;
    prev_rd = o_read;
    prev_wr = o_write;
    i_data_in = (bus_idx < bus_q.size()) ? bus_q[bus_idx] : 8'h00;
  end

  // Scoreboard monitor: pops on every accepted pixel, checks stability during stalls.
  logic        hold_pend = 1'b0;
  logic [23:0] held_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) chk("stall_stable", {39'd0, o_pixel_stb, o_pixel_data}, {39'd0, 1'b1, held_data});
      if (o_pixel_stb && i_pixel_rdy) begin
        if (exp_q.size() == 0) chk("pixel_unexpected", 64'(o_pixel_data), 64'hDEAD_0000_0000_0000);
        else chk("pixel", 64'(o_pixel_data), 64'(exp_q.pop_front()));
      end
      hold_pend = o_pixel_stb && !i_pixel_rdy;
      held_data = o_pixel_data;
    end
  end

  logic [63:0] m_wr, m_rd, m_stb, m_done, m_busy, m_den, m_cmd0;
  logic [7:0]  d1;
  logic [38:0] snap;
  localparam logic [38:0] ResetSnap = {7'b0000001, 8'h00, 24'h000000};

  function automatic logic [38:0] take_snap();
    return {o_busy, o_done_stb, o_pixel_stb, o_write, o_read, o_data_out_en, o_cmd_mode,
            o_data_out, o_pixel_data};
  endfunction

  // Entered just after a rising edge; that cycle is cycle 0 (start high).
  task automatic run(input logic [31:0] npx, input int ncyc, input int rdy_cyc, input int en_cyc,
                     input int rst_cyc, input logic [63:0] restart);
    m_wr = '0; m_rd = '0; m_stb = '0; m_done = '0; m_busy = '0; m_den = '0; m_cmd0 = '0;
    d1 = '0; snap = '0;
    i_pixel_rdy  = (rdy_cyc <= 0);
    i_start_stb  = 1'b1;
    i_num_pixels = npx;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      m_wr[k] = o_write; m_rd[k] = o_read; m_stb[k] = o_pixel_stb; m_done[k] = o_done_stb;
      m_busy[k] = o_busy; m_den[k] = o_data_out_en; m_cmd0[k] = !o_cmd_mode;
      if (k == 1) d1 = o_data_out;
      if (rst_cyc >= 0 && k == rst_cyc + 1) snap = take_snap();
      @(posedge clk);
      #1;
      i_start_stb = (k + 1 < 64) ? restart[k + 1] : 1'b0;
      if (i_start_stb) i_num_pixels = 32'd5;
      if (k + 1 == rdy_cyc) i_pixel_rdy = 1'b1;
      if (k + 1 == en_cyc) i_enable = 1'b0;
      rst = (k + 1 == rst_cyc);
    end
    i_enable = 1'b1; rst = 1'b0; i_pixel_rdy = 1'b1; i_start_stb = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 64'(take_snap()), 64'(ResetSnap));
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // 1 pixel, nominal latency
    bus_q = '{8'hFF, 8'h12, 8'h34, 8'h56};
    exp_q.push_back(24'h123456);
    run(32'd1, 24, 0, -1, -1, 64'd0);
    chk("t1_write", m_wr, 64'h6);
    chk("t1_cmd_byte", 64'(d1), 64'h2E);
    chk("t1_read", m_rd, 64'hDB60);
    chk("t1_data_en", m_den, 64'hE);
    chk("t1_cmd_mode_low", m_cmd0, 64'hE);
    chk("t1_stb", m_stb, 64'h1_0000);
    chk("t1_done", m_done, 64'h2_0000);
    chk("t1_busy", m_busy, 64'h1_FFFE);
    chk("t1_drained", 64'(exp_q.size()), 64'd0);

    // 3 pixels, consumer stalls 5 cycles on the first
    bus_q = '{8'hFF, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9};
    exp_q.push_back(24'hA1A2A3); exp_q.push_back(24'hA4A5A6); exp_q.push_back(24'hA7A8A9);
    run(32'd3, 48, 21, -1, -1, 64'd0);
    chk("t2_stb", m_stb, 64'h0000_0080_403F_0000);
    chk("t2_no_read_in_stall", (m_rd >> 16) & 64'h3F, 64'd0);
    chk("t2_read", m_rd, 64'h0000_006D_B6C0_DB60);
    chk("t2_done", m_done, 64'h0000_0100_0000_0000);
    chk("t2_busy", m_busy, 64'h0000_00FF_FFFF_FFFE);
    chk("t2_drained", 64'(exp_q.size()), 64'd0);

    // zero pixels
    run(32'd0, 8, 0, -1, -1, 64'd0);
    chk("t3_write", m_wr, 64'd0);
    chk("t3_read", m_rd, 64'd0);
    chk("t3_busy", m_busy, 64'd0);
    chk("t3_done", m_done, 64'h2);

    // abort via enable at cycle 12, then a clean restart
    bus_q = '{8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run(32'd4, 20, 0, 12, -1, 64'd0);
    chk("t4_read", m_rd, 64'h1B60);
    chk("t4_done", m_done, 64'd0);
    chk("t4_busy", m_busy, 64'h1FFE);
    chk("t4_stb", m_stb, 64'd0);
    chk("t4_data_en", m_den, 64'hE);
    bus_q = '{8'hFF, 8'hCA, 8'hFE, 8'h01};
    exp_q.push_back(24'hCAFE01);
    run(32'd1, 24, 0, -1, -1, 64'd0);
    chk("t4b_write", m_wr, 64'h6);
    chk("t4b_cmd_byte", 64'(d1), 64'h2E);
    chk("t4b_done", m_done, 64'h2_0000);
    chk("t4b_drained", 64'(exp_q.size()), 64'd0);

    // synchronous reset during a byte read
    bus_q = '{8'hFF, 8'h77, 8'h88, 8'h99};
    run(32'd1, 20, 0, -1, 9, 64'd0);
    chk("t5_reset_snap", 64'(snap), 64'(ResetSnap));
    chk("t5_no_read_after", m_rd >> 10, 64'd0);
    chk("t5_done", m_done, 64'd0);

    // start pulses while busy are ignored
    bus_q = '{8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    exp_q.push_back(24'h010203); exp_q.push_back(24'h040506);
    run(32'd2, 32, 0, -1, -1, 64'h0010_0020);
    chk("t6_done", m_done, 64'h400_0000);
    chk("t6_busy", m_busy, 64'h3FF_FFFE);
    chk("t6_write", m_wr, 64'h6);
    chk("t6_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
